// File: rtl/median_filter_pkg.sv
// Shared types and helpers for the median_filter frame sequencer.
package median_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    DRAIN,
    DONE,
    ERROR
  } ctrl_state_e;

  function automatic int pix_total(input int len, input int height);
    return len * height;
  endfunction

endpackage

// File: rtl/pix_pos_counter.sv
// Raster position tracker: walks col/row across one frame and flags the first
// pixel, each line end and the final pixel of the frame.
module pix_pos_counter #(
  parameter int LEN    = 4,
  parameter int HEIGHT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int COL_W = $clog2(LEN);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_comb begin
    sof = (col == '0) && (row == '0);
    eol = (col == COL_LAST);
    eof = (col == COL_LAST) && (row == ROW_LAST);
  end

  // Column wraps after each line end, row wraps after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer around median_filter: starts the filter, gates one frame of
// source pixels into it, then counts, tags and forwards the filtered pixels.
module median_frame_ctrl
  import median_filter_pkg::*;
#(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_req_i,
  input  logic              abort_i,
  input  logic              clr_err_i,
  input  logic              src_pix_valid_i,
  input  logic [DATA_W-1:0] src_pix_data_i,
  output logic              mf_start_o,
  output logic              mf_pix_valid_o,
  output logic [DATA_W-1:0] mf_pix_data_o,
  input  logic              mf_done_i,
  input  logic              mf_pix_valid_i,
  input  logic [DATA_W-1:0] mf_pix_data_i,
  output logic              dst_pix_valid_o,
  output logic [DATA_W-1:0] dst_pix_data_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              eof_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_o,
  output logic [15:0]       drop_cnt_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int N     = pix_total(IMAGE_LEN, IMAGE_HEIGHT);
  localparam int CNT_W = $clog2(N + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  ctrl_state_e state, next_state;

  logic [CNT_W-1:0] out_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_seen;
  logic             clear, in_take, out_take, out_full, done_any;
  logic             tmo_hit, complete, err_set;
  logic             in_sof_unused, in_eol_unused, in_eof;
  logic             out_sof, out_eol, out_eof;

  assign clear    = abort_i || (state == IDLE);
  assign in_take  = src_pix_valid_i && (state == FEED);
  assign out_full = (out_cnt == N_CNT);
  assign out_take = mf_pix_valid_i && ((state == FEED) || (state == DRAIN)) && !out_full;
  assign done_any = done_seen || mf_done_i;
  assign tmo_hit  = (state == DRAIN) && !mf_pix_valid_i && (tmo_cnt == TMO_LAST);
  assign complete = (state == DRAIN) && done_any && (out_full || (out_take && out_eof));
  assign err_set  = (state == DRAIN) && (next_state == ERROR);

  pix_pos_counter #(.LEN(IMAGE_LEN), .HEIGHT(IMAGE_HEIGHT)) u_in_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .adv   (in_take),
    .sof   (in_sof_unused),
    .eol   (in_eol_unused),
    .eof   (in_eof)
  );

  pix_pos_counter #(.LEN(IMAGE_LEN), .HEIGHT(IMAGE_HEIGHT)) u_out_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .adv   (out_take),
    .sof   (out_sof),
    .eol   (out_eol),
    .eof   (out_eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Abort beats everything; completion beats the drain timeout.
  always_comb begin
    next_state = state;
    if (abort_i && (state != IDLE)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (frame_req_i) next_state = START;
        START:   next_state = FEED;
        FEED:    if (in_take && in_eof) next_state = DRAIN;
        DRAIN: begin
          if (complete)     next_state = DONE;
          else if (tmo_hit) next_state = ERROR;
        end
        DONE:    next_state = IDLE;
        ERROR:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state != IDLE);
    mf_start_o   = (state == START);
    frame_done_o = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mf_pix_valid_o  <= 1'b0;
      mf_pix_data_o   <= '0;
      dst_pix_valid_o <= 1'b0;
      dst_pix_data_o  <= '0;
      sof_o           <= 1'b0;
      eol_o           <= 1'b0;
      eof_o           <= 1'b0;
    end else begin
      mf_pix_valid_o  <= in_take;
      mf_pix_data_o   <= src_pix_data_i;
      dst_pix_valid_o <= out_take;
      dst_pix_data_o  <= mf_pix_data_i;
      sof_o           <= out_take && out_sof;
      eol_o           <= out_take && out_eol;
      eof_o           <= out_take && out_eof;
    end
  end

  // Frame bookkeeping; a new timeout outranks a simultaneous error clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt     <= '0;
      done_seen   <= 1'b0;
      tmo_cnt     <= '0;
      err_o       <= 1'b0;
      drop_cnt_o  <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (clear) begin
        out_cnt   <= '0;
        done_seen <= 1'b0;
      end else begin
        if (out_take) out_cnt <= out_cnt + 1'b1;
        if (mf_done_i && ((state == FEED) || (state == DRAIN))) done_seen <= 1'b1;
      end
      if ((state != DRAIN) || abort_i || mf_pix_valid_i) tmo_cnt <= '0;
      else                                               tmo_cnt <= tmo_cnt + 1'b1;
      if (err_set)        err_o <= 1'b1;
      else if (clr_err_i) err_o <= 1'b0;
      if (src_pix_valid_i && (state != FEED) && (drop_cnt_o != 16'hFFFF))
        drop_cnt_o <= drop_cnt_o + 16'd1;
      if (state == DONE) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl on a 4x3 frame; the bench itself plays the
// median filter by echoing gated pixels back inverted.
module tb_median_frame_ctrl;

  localparam int LEN    = 4;
  localparam int HEIGHT = 3;
  localparam int NPIX   = LEN * HEIGHT;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frameReq, abortIn, clrErr;
  logic       srcValid;
  logic [7:0] srcData;
  logic       mf_start_o, mf_pix_valid_o;
  logic [7:0] mf_pix_data_o;
  logic       mf_done_i, mf_pix_valid_i;
  logic [7:0] mf_pix_data_i;
  logic       dst_pix_valid_o;
  logic [7:0] dst_pix_data_o;
  logic       sof_o, eol_o, eof_o, busy_o, frame_done_o, err_o;
  logic [15:0] drop_cnt_o, frame_cnt_o;

  typedef struct {
    int idleValids;
    int srcBeats;
    int doneAt;
    int expMf;
    int expDst;
    int expDrop;
    int expDoneBeat;
  } frame_vec_t;

  frame_vec_t vecs[4];

  int testsRun = 0;
  int failCnt  = 0;
  int startPulses, mfBeats, dstBeats, sofCnt, eolCnt, eofCnt, donePulses, doneAtBeat;
  int expDrop, expFrames;
  logic [7:0] expBase;
  logic [7:0] monExpData;
  logic [2:0] monExpTags;

  logic [7:0] filtQ[$];
  bit   filtEn;
  bit   filtDoneFired;
  int   filtDoneAt, filtEmitted;

  median_frame_ctrl #(
    .IMAGE_LEN(LEN), .IMAGE_HEIGHT(HEIGHT), .TIMEOUT_CYC(TMO), .DATA_W(8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_req_i     (frameReq),
    .abort_i         (abortIn),
    .clr_err_i       (clrErr),
    .src_pix_valid_i (srcValid),
    .src_pix_data_i  (srcData),
    .mf_start_o      (mf_start_o),
    .mf_pix_valid_o  (mf_pix_valid_o),
    .mf_pix_data_o   (mf_pix_data_o),
    .mf_done_i       (mf_done_i),
    .mf_pix_valid_i  (mf_pix_valid_i),
    .mf_pix_data_i   (mf_pix_data_i),
    .dst_pix_valid_o (dst_pix_valid_o),
    .dst_pix_data_o  (dst_pix_data_o),
    .sof_o           (sof_o),
    .eol_o           (eol_o),
    .eof_o           (eof_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .err_o           (err_o),
    .drop_cnt_o      (drop_cnt_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Filter model: one echoed beat per cycle, one-cycle done pulse after doneAt beats.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mf_pix_valid_i = 1'b0;
      mf_done_i      = 1'b0;
    end else begin
      mf_done_i = 1'b0;
      if (filtEn && !filtDoneFired && (filtEmitted >= filtDoneAt)) begin
        mf_done_i     = 1'b1;
        filtDoneFired = 1'b1;
      end
      if (filtEn && (filtQ.size() > 0)) begin
        mf_pix_valid_i = 1'b1;
        mf_pix_data_i  = ~filtQ.pop_front();
        filtEmitted++;
      end else begin
        mf_pix_valid_i = 1'b0;
      end
    end
  end

  // Monitor on the falling edge: counts events and checks each sink beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mf_start_o) startPulses++;
      if (mf_pix_valid_o) begin
        mfBeats++;
        filtQ.push_back(mf_pix_data_o);
      end
      if (dst_pix_valid_o) begin
        monExpTags = {dstBeats == 0, (dstBeats % LEN) == LEN - 1, dstBeats == NPIX - 1};
        monExpData = ~(expBase + 8'(dstBeats));
        checkOutput($sformatf("tags beat %0d", dstBeats), int'({sof_o, eol_o, eof_o}), int'(monExpTags));
        checkOutput($sformatf("data beat %0d", dstBeats), int'(dst_pix_data_o), int'(monExpData));
        if (sof_o) sofCnt++;
        if (eol_o) eolCnt++;
        if (eof_o) eofCnt++;
        dstBeats++;
      end
      if (frame_done_o) begin
        donePulses++;
        doneAtBeat = dstBeats;
      end
    end
  end

  task automatic resetScoreboard(input int doneAt);
    startPulses = 0; mfBeats = 0; dstBeats = 0;
    sofCnt = 0; eolCnt = 0; eofCnt = 0;
    donePulses = 0; doneAtBeat = -1;
    filtDoneAt = doneAt; filtEmitted = 0; filtDoneFired = 1'b0;
    filtQ.delete();
  endtask

  task automatic startFrame(input int srcBeats);
    frameReq = 1'b1;
    step();
    frameReq = 1'b0;
    step();
    for (int i = 0; i < srcBeats; i++) begin
      srcValid = 1'b1;
      srcData  = expBase + 8'(i);
      step();
    end
    srcValid = 1'b0;
  endtask

  task automatic applyStimulus(input frame_vec_t v);
    int n;
    for (int i = 0; i < v.idleValids; i++) begin
      srcValid = 1'b1;
      step();
    end
    srcValid = 1'b0;
    resetScoreboard(v.doneAt);
    startFrame(v.srcBeats);
    n = 0;
    while (busy_o && (n < 200)) begin
      step();
      n++;
    end
    expDrop   += v.expDrop;
    expFrames += 1;
    checkOutput("frame ends idle", int'(busy_o), 0);
    checkOutput("start pulses", startPulses, 1);
    checkOutput("mf beats", mfBeats, v.expMf);
    checkOutput("dst beats", dstBeats, v.expDst);
    checkOutput("sof count", sofCnt, 1);
    checkOutput("eol count", eolCnt, HEIGHT);
    checkOutput("eof count", eofCnt, 1);
    checkOutput("frame_done pulses", donePulses, 1);
    checkOutput("frame_done at beat", doneAtBeat, v.expDoneBeat);
    checkOutput("drop_cnt", int'(drop_cnt_o), expDrop);
    checkOutput("frame_cnt", int'(frame_cnt_o), expFrames);
    checkOutput("err after frame", int'(err_o), 0);
  endtask

  initial begin
    // idleValids, srcBeats, doneAt, expMf, expDst, expDrop, expDoneBeat
    vecs[0] = '{0, 12, 12, 12, 12, 0, 12};
    vecs[1] = '{3, 14, 12, 12, 12, 5, 12};
    vecs[2] = '{0, 12, 10, 12, 12, 0, 12};
    vecs[3] = '{1, 13, 11, 12, 12, 2, 12};

    rst_n = 1'b0; frameReq = 1'b0; abortIn = 1'b0; clrErr = 1'b0;
    srcValid = 1'b0; srcData = 8'h00;
    mf_pix_valid_i = 1'b0; mf_pix_data_i = 8'h00; mf_done_i = 1'b0;
    filtEn = 1'b1; expBase = 8'h10; expDrop = 0; expFrames = 0;
    resetScoreboard(NPIX);

    #12;
    checkOutput("reset busy", int'(busy_o), 0);
    checkOutput("reset start", int'(mf_start_o), 0);
    checkOutput("reset valids", int'({mf_pix_valid_o, dst_pix_valid_o}), 0);
    checkOutput("reset counters", int'({drop_cnt_o, frame_cnt_o}), 0);
    checkOutput("reset err", int'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      expBase = 8'h10 + 8'(i * 32);
      applyStimulus(vecs[i]);
    end

    // Abort after five pixels, then a clean frame must restart at sof.
    resetScoreboard(NPIX);
    expBase = 8'hA0;
    frameReq = 1'b1; step(); frameReq = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      srcValid = 1'b1;
      srcData  = expBase + 8'(i);
      step();
    end
    srcValid = 1'b0;
    abortIn = 1'b1;
    step();
    abortIn = 1'b0;
    checkOutput("abort busy", int'(busy_o), 0);
    checkOutput("abort frame_done", donePulses, 0);
    checkOutput("abort frame_cnt", int'(frame_cnt_o), expFrames);
    step();
    step();
    expBase = 8'hC0;
    applyStimulus(vecs[0]);

    // Starved drain: error after exactly TMO silent drain cycles.
    resetScoreboard(1000);
    filtEn = 1'b0;
    expBase = 8'h40;
    startFrame(NPIX);
    repeat (TMO - 1) step();
    checkOutput("tmo err early", int'(err_o), 0);
    checkOutput("tmo busy early", int'(busy_o), 1);
    step();
    checkOutput("tmo err set", int'(err_o), 1);
    step();
    checkOutput("tmo back idle", int'(busy_o), 0);
    checkOutput("tmo err sticky", int'(err_o), 1);
    checkOutput("tmo no frame_done", donePulses, 0);
    checkOutput("tmo mf beats", mfBeats, NPIX);
    clrErr = 1'b1;
    step();
    clrErr = 1'b0;
    checkOutput("clr err", int'(err_o), 0);

    // Second starved drain with clear held: the new timeout must still set err.
    resetScoreboard(1000);
    startFrame(NPIX);
    clrErr = 1'b1;
    repeat (TMO) step();
    checkOutput("tmo vs clr err", int'(err_o), 1);
    step();
    clrErr = 1'b0;
    checkOutput("clr after tmo", int'(err_o), 0);
    checkOutput("tmo2 idle", int'(busy_o), 0);
    checkOutput("tmo frame_cnt", int'(frame_cnt_o), expFrames);
    filtQ.delete();
    filtEn = 1'b1;

    // Asynchronous reset in the middle of DRAIN.
    resetScoreboard(NPIX);
    expBase = 8'h60;
    startFrame(NPIX);
    step();
    step();
    checkOutput("pre-reset busy", int'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async busy", int'(busy_o), 0);
    checkOutput("async valids", int'({mf_pix_valid_o, dst_pix_valid_o}), 0);
    checkOutput("async tags", int'({sof_o, eol_o, eof_o}), 0);
    checkOutput("async pulses", int'({mf_start_o, frame_done_o, err_o}), 0);
    checkOutput("async drop_cnt", int'(drop_cnt_o), 0);
    checkOutput("async frame_cnt", int'(frame_cnt_o), 0);
    expDrop = 0;
    expFrames = 0;
    step();
    step();
    filtQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expBase = 8'h80;
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
